// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that lends one memory-mapped I2C master to NREQ requesters:
// programs NBY/ADR/TDR/CFG, polls CFG for completion, fetches RDR, clears the command.
module i2c_txn_arbiter #(
  parameter int NREQ = 2,
  parameter int TO_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    req_read_i,
  input  logic [7*NREQ-1:0]  req_addr_i,
  input  logic [3*NREQ-1:0]  req_nby_i,
  input  logic [32*NREQ-1:0] req_wdata_i,
  input  logic [2*NREQ-1:0]  req_speed_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic               err_o,
  output logic [31:0]        rdata_o,
  output logic               busy_o,
  output logic               m_write_o,
  output logic [3:0]         m_be_o,
  output logic [4:0]         m_addr_o,
  output logic [31:0]        m_wdata_o,
  input  logic [31:0]        m_rdata_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0] A_NBY = 5'd0, A_ADR = 5'd4, A_RDR = 5'd8, A_TDR = 5'd12, A_CFG = 5'd16;

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_WR_NBY, S_WR_ADR, S_WR_TDR, S_WR_CFG,
    S_POLL_A, S_POLL_D, S_RD_A, S_RD_D, S_CLR, S_DONE
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q, done_q;
  logic            busy_q, err_q, err_flag_q, rd_q;
  logic [6:0]      addr_q;
  logic [31:0]     wdata_q, rdata_q, m_wdata_q;
  logic [1:0]      speed_q;
  logic [TO_W-1:0] to_q;
  logic            m_write_q;
  logic [3:0]      m_be_q;
  logic [4:0]      m_addr_q;

  logic [6:0]  addr_a  [NREQ];
  logic [2:0]  nby_a   [NREQ];
  logic [31:0] wdata_a [NREQ];
  logic [1:0]  speed_a [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_a[k]  = req_addr_i[7*k +: 7];
    assign nby_a[k]   = req_nby_i[3*k +: 3];
    assign wdata_a[k] = req_wdata_i[32*k +: 32];
    assign speed_a[k] = req_speed_i[2*k +: 2];
  end

  logic          win_vld_d;
  logic [PW-1:0] win_d, cand;
  logic [2:0]    nby_sel;
  logic          poll_done;

  // Search starts one past the last winner, so ptr_q doubles as the granted index.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_vld_d && req_i[cand]) begin
        win_vld_d = 1'b1;
        win_d     = cand;
      end
    end
  end

  always_comb begin
    nby_sel   = (nby_a[ptr_q] == 3'd0) ? 3'd1 : nby_a[ptr_q];
    poll_done = rd_q ? (m_rdata_i[3:2] == 2'b11) : (m_rdata_i[1:0] == 2'b11);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      speed_q    <= '0;
      rdata_q    <= '0;
      to_q       <= '0;
      m_write_q  <= 1'b0;
      m_be_q     <= 4'h0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      m_write_q <= 1'b0;
      m_be_q    <= 4'h0;
      done_q    <= '0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (win_vld_d) begin
          gnt_q   <= NREQ'(1) << win_d;
          busy_q  <= 1'b1;
          ptr_q   <= win_d;
          state_q <= S_GRANT;
        end
        S_GRANT: begin
          rd_q       <= req_read_i[ptr_q];
          addr_q     <= addr_a[ptr_q];
          wdata_q    <= wdata_a[ptr_q];
          speed_q    <= speed_a[ptr_q];
          err_flag_q <= 1'b0;
          m_write_q  <= 1'b1;
          m_be_q     <= 4'hF;
          m_addr_q   <= A_NBY;
          m_wdata_q  <= {29'b0, nby_sel};
          state_q    <= S_WR_NBY;
        end
        S_WR_NBY: begin
          m_write_q <= 1'b1;
          m_be_q    <= 4'hF;
          m_addr_q  <= A_ADR;
          m_wdata_q <= {25'b0, addr_q};
          state_q   <= S_WR_ADR;
        end
        S_WR_ADR: begin
          m_write_q <= 1'b1;
          m_be_q    <= 4'hF;
          if (rd_q) begin
            m_addr_q  <= A_CFG;
            m_wdata_q <= {26'b0, speed_q, 4'b0100};
            state_q   <= S_WR_CFG;
          end else begin
            m_addr_q  <= A_TDR;
            m_wdata_q <= wdata_q;
            state_q   <= S_WR_TDR;
          end
        end
        S_WR_TDR: begin
          m_write_q <= 1'b1;
          m_be_q    <= 4'hF;
          m_addr_q  <= A_CFG;
          m_wdata_q <= {26'b0, speed_q, 4'b0001};
          state_q   <= S_WR_CFG;
        end
        S_WR_CFG: begin
          m_addr_q  <= A_CFG;
          m_wdata_q <= '0;
          to_q      <= '0;
          state_q   <= S_POLL_A;
        end
        S_POLL_A: begin
          if (to_q != '1) to_q <= to_q + 1'b1;
          state_q <= S_POLL_D;
        end
        S_POLL_D: begin
          if (to_q != '1) to_q <= to_q + 1'b1;
          // Completion is checked before the timeout so a late success still counts.
          if (poll_done && rd_q) begin
            m_addr_q <= A_RDR;
            state_q  <= S_RD_A;
          end else if (poll_done || to_q == '1) begin
            err_flag_q <= !poll_done;
            m_write_q  <= 1'b1;
            m_be_q     <= 4'hF;
            m_addr_q   <= A_CFG;
            m_wdata_q  <= {26'b0, speed_q, 4'b0000};
            state_q    <= S_CLR;
          end else begin
            state_q <= S_POLL_A;
          end
        end
        S_RD_A: state_q <= S_RD_D;
        S_RD_D: begin
          rdata_q   <= m_rdata_i;
          m_write_q <= 1'b1;
          m_be_q    <= 4'hF;
          m_addr_q  <= A_CFG;
          m_wdata_q <= {26'b0, speed_q, 4'b0000};
          state_q   <= S_CLR;
        end
        S_CLR: begin
          done_q  <= gnt_q;
          err_q   <= err_flag_q;
          if (err_flag_q) rdata_q <= '0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign busy_o    = busy_q;
  assign m_write_o = m_write_q;
  assign m_be_o    = m_be_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;

endmodule
